// File: rtl/ddr_test_pkg.sv
// Shared types and constants for the multi-channel DDR traffic generator/checker.
package ddr_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_XOR = 32'hA5A5_A5A5;

    localparam logic PAT_INCR = 1'b0;
    localparam logic PAT_LFSR = 1'b1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/ddr_test_pattern.sv
// Beat pattern generator: seeded from a burst address, steps once per beat,
// 32-bit value replicated across the data word.
module ddr_test_pattern #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  pat_sel,
    input  logic [31:0]           seed_addr,
    output logic [DATA_WIDTH-1:0] word
);
    import ddr_test_pkg::*;

    localparam int unsigned LANES      = DATA_WIDTH / 32;
    localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);

    logic [31:0] cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (load) begin
            cur <= (pat_sel == PAT_LFSR) ? (seed_addr ^ LFSR_SEED_XOR) : seed_addr;
        end else if (advance) begin
            cur <= (pat_sel == PAT_LFSR) ? lfsr_next(cur) : cur + BEAT_BYTES;
        end
    end

    assign word = {LANES{cur}};

endmodule

// File: rtl/ddr_test_gen_mc.sv
// Multi-channel DDR traffic generator/checker: channels take round-robin turns
// writing one burst into their region, reading it back and comparing each beat.
//
// state    | meaning
// IDLE     | waiting for test_en; status from the last run is held
// WR_CMD   | wstart asserted until wready
// WR_DATA  | BURST_LEN write beats, no backpressure
// RD_CMD   | rstart asserted until rready
// RD_DATA  | compare returned beats, watch for read timeout
// CHECK    | count burst, advance channel/pointer, decide continue or stop
// DONE     | done asserted; waits for test_en low
module ddr_test_gen_mc #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned REGION_BYTES = 32'h0100_0000,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned TIMEOUT_CYC  = 4096,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test_en,
    input  logic                  pattern_sel,
    input  logic [15:0]           num_iter,
    output logic                  wstart,
    input  logic                  wready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [LEN_WIDTH-1:0]  wdata_len,
    output logic                  wdata_vld,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  rstart,
    input  logic                  rready,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [LEN_WIDTH-1:0]  rdata_len,
    input  logic                  rdata_vld,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_flag,
    output logic                  timeout,
    output logic [15:0]           err_cnt,
    output logic [31:0]           iter_cnt,
    output logic [CH_W-1:0]       err_ch
);
    import ddr_test_pkg::*;

    localparam int unsigned BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int unsigned PTRS        = REGION_BYTES / BURST_BYTES;
    localparam int unsigned PTR_W       = (PTRS > 1) ? $clog2(PTRS) : 1;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);

    state_t                state;
    logic                  pat_q;
    logic [15:0]           num_iter_q;
    logic [CH_W-1:0]       ch;
    logic [PTR_W-1:0]      ptr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  wr_load;
    logic                  wr_adv;
    logic                  rd_load;
    logic                  rd_adv;
    logic [DATA_WIDTH-1:0] exp_word;
    logic                  err_event;
    logic                  last_iter;
    logic [CH_W-1:0]       ch_nxt;
    logic [PTR_W-1:0]      ptr_nxt;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [CH_W-1:0]  c,
                                                         input logic [PTR_W-1:0] p);
        logic [63:0] a;
        a = 64'(BASE_ADDR) + 64'(c) * 64'(REGION_BYTES) + 64'(p) * 64'(BURST_BYTES);
        return a[ADDR_WIDTH-1:0];
    endfunction

    assign wr_load   = (state == ST_WR_CMD) && wready;
    assign wr_adv    = (state == ST_WR_DATA);
    assign rd_load   = (state == ST_RD_CMD) && rready;
    assign rd_adv    = (state == ST_RD_DATA) && rdata_vld;
    // Any beat outside RD_DATA is unexpected and counts as a miscompare.
    assign err_event = rdata_vld && ((state != ST_RD_DATA) || (rdata != exp_word));
    assign last_iter = (num_iter_q != 16'd0) && ((iter_cnt + 32'd1) == {16'd0, num_iter_q});

    always_comb begin
        ch_nxt  = ch + CH_W'(1);
        ptr_nxt = ptr;
        if (ch == CH_W'(NUM_CH - 1)) begin
            ch_nxt  = '0;
            ptr_nxt = (ptr == PTR_W'(PTRS - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    ddr_test_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_load),
        .advance   (wr_adv),
        .pat_sel   (pat_q),
        .seed_addr (32'(addr_q)),
        .word      (wdata)
    );

    ddr_test_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pat (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .advance   (rd_adv),
        .pat_sel   (pat_q),
        .seed_addr (32'(addr_q)),
        .word      (exp_word)
    );

    assign waddr     = addr_q;
    assign raddr     = addr_q;
    assign wdata_len = LEN_WIDTH'(BURST_BYTES);
    assign rdata_len = LEN_WIDTH'(BURST_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pat_q      <= PAT_INCR;
            num_iter_q <= '0;
            ch         <= '0;
            ptr        <= '0;
            addr_q     <= '0;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            wstart     <= 1'b0;
            wdata_vld  <= 1'b0;
            rstart     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_flag   <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= '0;
            iter_cnt   <= '0;
            err_ch     <= '0;
        end else begin
            if (err_event) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                err_flag <= 1'b1;
                if (!err_flag) err_ch <= ch;
            end

            case (state)
                ST_IDLE: begin
                    if (test_en) begin
                        pat_q      <= pattern_sel;
                        num_iter_q <= num_iter;
                        ch         <= '0;
                        ptr        <= '0;
                        addr_q     <= BASE_ADDR;
                        done       <= 1'b0;
                        err_flag   <= 1'b0;
                        timeout    <= 1'b0;
                        err_cnt    <= '0;
                        iter_cnt   <= '0;
                        err_ch     <= '0;
                        busy       <= 1'b1;
                        wstart     <= 1'b1;
                        state      <= ST_WR_CMD;
                    end
                end
                ST_WR_CMD: begin
                    if (wready) begin
                        wstart    <= 1'b0;
                        wdata_vld <= 1'b1;
                        beat_cnt  <= BEAT_W'(BURST_LEN - 1);
                        state     <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (beat_cnt == '0) begin
                        wdata_vld <= 1'b0;
                        rstart    <= 1'b1;
                        state     <= ST_RD_CMD;
                    end else begin
                        beat_cnt <= beat_cnt - BEAT_W'(1);
                    end
                end
                ST_RD_CMD: begin
                    if (rready) begin
                        rstart   <= 1'b0;
                        beat_cnt <= BEAT_W'(BURST_LEN - 1);
                        tmo_cnt  <= TMO_W'(TIMEOUT_CYC - 1);
                        state    <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rdata_vld) begin
                        tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
                        if (beat_cnt == '0) state <= ST_CHECK;
                        else beat_cnt <= beat_cnt - BEAT_W'(1);
                    end else if (tmo_cnt == '0) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                ST_CHECK: begin
                    iter_cnt <= iter_cnt + 32'd1;
                    ch       <= ch_nxt;
                    ptr      <= ptr_nxt;
                    addr_q   <= burst_addr(ch_nxt, ptr_nxt);
                    if (last_iter || !test_en) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        wstart <= 1'b1;
                        state  <= ST_WR_CMD;
                    end
                end
                ST_DONE: begin
                    if (!test_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
